// File: rtl/module_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// the word/byte address relationship used when writing the image.
package module_imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_e;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;

endpackage : module_imem_loader_pkg

// File: rtl/module_watchdog_counter.sv
// Idle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT. TIMEOUT=0 disables it entirely.
module module_watchdog_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT > 0) begin : g_enabled
            localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT - 1);
            localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

            logic [CNT_W-1:0] count_r;

            // Idle cycle counter, saturating at TIMEOUT.
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_r <= '0;
                end else if (clear) begin
                    count_r <= '0;
                end else if (enable && (count_r != LIMIT)) begin
                    count_r <= count_r + ONE;
                end else begin
                    count_r <= count_r;
                end
            end

            // Fires during the idle cycle that brings the count to TIMEOUT.
            assign expired = enable && !clear && (count_r == LAST_IDLE);
        end else begin : g_disabled
            logic unused_s;
            assign unused_s = clk ^ rst ^ clear ^ enable;
            assign expired  = 1'b0;
        end
    endgenerate

endmodule : module_watchdog_counter

// File: rtl/module_imem_loader.sv
// Boot loader for the instruction memory: streams words into consecutive
// 4-byte addresses while holding the CPU, then hands addr back to the PC.
module module_imem_loader
    import module_imem_loader_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int MEMORY       = 1024,
    parameter int TIMEOUT      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [ADDRESS_BITS-1:0] load_len,
    input  logic                    in_valid,
    input  logic [WORD_SIZE-1:0]    in_data,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] pc,
    output logic                    prog,
    output logic [ADDRESS_BITS-1:0] addr,
    output logic [WORD_SIZE-1:0]    code,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_error
);

    localparam logic [ADDRESS_BITS:0]   MEM_LIMIT = (ADDRESS_BITS + 1)'(MEMORY);
    localparam logic [ADDRESS_BITS-1:0] ONE_A     = ADDRESS_BITS'(1);

    loader_state_e           state_r;
    logic                    prog_r;
    logic [WORD_SIZE-1:0]    code_r;
    logic [ADDRESS_BITS-1:0] load_addr_r;
    logic                    cpu_hold_r;
    logic                    in_ready_r;
    logic                    load_done_r;
    logic                    load_error_r;
    logic [ADDRESS_BITS-1:0] count_r;
    logic [ADDRESS_BITS-1:0] len_r;

    logic                    transfer_s;
    logic                    len_ok_s;
    logic                    last_word_s;
    logic                    wd_clear_s;
    logic                    wd_enable_s;
    logic                    wd_expired_s;

    // in_ready_r is only ever set while in LOAD, so it qualifies the handshake alone.
    assign transfer_s  = in_valid && in_ready_r;
    assign len_ok_s    = (load_len != '0) && ({1'b0, load_len} <= MEM_LIMIT);
    assign last_word_s = (count_r == (len_r - ONE_A));
    assign wd_clear_s  = (state_r != ST_LOAD) || transfer_s;
    assign wd_enable_s = (state_r == ST_LOAD) && !transfer_s;

    module_watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Loader FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            prog_r       <= 1'b0;
            code_r       <= '0;
            load_addr_r  <= '0;
            cpu_hold_r   <= 1'b1;
            in_ready_r   <= 1'b0;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
            count_r      <= '0;
            len_r        <= '0;
        end else begin
            prog_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (load_start && len_ok_s) begin
                        state_r      <= ST_LOAD;
                        in_ready_r   <= 1'b1;
                        cpu_hold_r   <= 1'b1;
                        load_done_r  <= 1'b0;
                        load_error_r <= 1'b0;
                        count_r      <= '0;
                        len_r        <= load_len;
                    end else if (load_start) begin
                        state_r      <= ST_ERROR;
                        in_ready_r   <= 1'b0;
                        cpu_hold_r   <= 1'b1;
                        load_done_r  <= 1'b0;
                        load_error_r <= 1'b1;
                    end else if (state_r == ST_DONE) begin
                        // Release the CPU only once the final write pulse has gone out.
                        cpu_hold_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (transfer_s) begin
                        prog_r      <= 1'b1;
                        code_r      <= in_data;
                        load_addr_r <= count_r << WORD_ADDR_SHIFT;
                        count_r     <= count_r + ONE_A;
                        if (last_word_s) begin
                            state_r     <= ST_DONE;
                            in_ready_r  <= 1'b0;
                            load_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else if (wd_expired_s) begin
                        state_r      <= ST_ERROR;
                        in_ready_r   <= 1'b0;
                        load_error_r <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    cpu_hold_r <= 1'b1;
                end
            endcase
        end
    end

    assign addr       = prog_r ? load_addr_r : pc;
    assign prog       = prog_r;
    assign code       = code_r;
    assign cpu_hold   = cpu_hold_r;
    assign in_ready   = in_ready_r;
    assign load_done  = load_done_r;
    assign load_error = load_error_r;

endmodule : module_imem_loader

// File: tb/tb_module_imem_loader.sv
// Self-checking bench for module_imem_loader: length table, directed
// multi-cycle sequences and randomized loads against a word-level model.
module tb_module_imem_loader;

    localparam int TO  = 8;
    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [31:0] load_len = 32'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic [31:0] pc = 32'h0000_1234;
    logic        prog;
    logic [31:0] addr;
    logic [31:0] code;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wdata[16];
    int          wgap[16];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_data_q[$];

    typedef struct {
        logic [31:0] len;
        logic        exp_ready;
        logic        exp_error;
    } len_vec_t;

    len_vec_t len_tbl[6];

    module_imem_loader #(
        .WORD_SIZE    (32),
        .ADDRESS_BITS (32),
        .MEMORY       (MEM),
        .TIMEOUT      (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pc         (pc),
        .prog       (prog),
        .addr       (addr),
        .code       (code),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Record every memory write the loader performs.
    always @(negedge clk) begin
        if (prog) begin
            obs_addr_q.push_back(addr);
            obs_data_q.push_back(code);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        load_start = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, obs_addr_q.size(), exp_addr_q.size());
        if (obs_addr_q.size() == exp_addr_q.size()) begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                check({tag, "_wr_addr"}, obs_addr_q[i], exp_addr_q[i]);
                check({tag, "_wr_data"}, obs_data_q[i], exp_data_q[i]);
            end
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        obs_addr_q.delete();
        obs_data_q.delete();
    endtask

    // Word-level model: each word i is offered after wgap[i] idle cycles;
    // TO consecutive idle cycles in a load abort it, otherwise word i lands at 4*i.
    task automatic do_load(input string tag, input int len);
        int idle;
        bit err;
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
        check({tag, "_start_ready"}, in_ready, 1);
        check({tag, "_start_hold"}, cpu_hold, 1);
        check({tag, "_start_done"}, load_done, 0);
        check({tag, "_start_err"}, load_error, 0);
        err = 1'b0;
        for (int i = 0; i < len && !err; i++) begin
            idle = 0;
            for (int g = 0; g < wgap[i] && !err; g++) begin
                in_valid = 1'b0;
                tick();
                idle++;
                err = (idle >= TO);
                check({tag, "_gap_err"}, load_error, err);
                check({tag, "_gap_ready"}, in_ready, !err);
            end
            if (!err) begin
                in_valid = 1'b1;
                in_data  = wdata[i];
                tick();
                in_valid = 1'b0;
                exp_addr_q.push_back(i * 4);
                exp_data_q.push_back(wdata[i]);
                check({tag, "_prog"}, prog, 1);
                check({tag, "_addr"}, addr, i * 4);
                check({tag, "_code"}, code, wdata[i]);
                check({tag, "_done_flag"}, load_done, (i == len - 1));
                check({tag, "_ready_after"}, in_ready, (i != len - 1));
                check({tag, "_hold_during"}, cpu_hold, 1);
            end
        end
        tick();
        check({tag, "_end_prog"}, prog, 0);
        check({tag, "_end_addr_pc"}, addr, pc);
        check({tag, "_end_ready"}, in_ready, 0);
        check({tag, "_end_err"}, load_error, err);
        check({tag, "_end_done"}, load_done, !err);
        check({tag, "_end_hold"}, cpu_hold, err);
        compare_writes(tag);
    endtask

    initial begin
        len_tbl[0] = '{32'd0,         1'b0, 1'b1};
        len_tbl[1] = '{32'd1025,      1'b0, 1'b1};
        len_tbl[2] = '{32'd1024,      1'b1, 1'b0};
        len_tbl[3] = '{32'd1,         1'b1, 1'b0};
        len_tbl[4] = '{32'hFFFF_FFFF, 1'b0, 1'b1};
        len_tbl[5] = '{32'd2,         1'b1, 1'b0};

        // Reset values.
        do_reset();
        tick();
        check("rst_hold", cpu_hold, 1);
        check("rst_prog", prog, 0);
        check("rst_ready", in_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_error, 0);
        check("rst_addr_pc", addr, 32'h0000_1234);

        // Basic three-word load, then the PC owns the address bus.
        pc = 32'h0000_000C;
        wdata[0] = 32'h2000_0001; wdata[1] = 32'h2080_0001; wdata[2] = 32'h0080_4000;
        for (int i = 0; i < 16; i++) wgap[i] = 0;
        do_load("basic", 3);
        check("basic_pc_addr", addr, 32'h0000_000C);

        // Watchdog: a 5-cycle gap survives, a 9-cycle gap aborts after word 0.
        wdata[0] = 32'hA5A5_0000; wdata[1] = 32'h5A5A_1111;
        wgap[0] = 0; wgap[1] = 5;
        do_load("gap5", 2);
        wgap[1] = 9;
        do_load("gap9", 2);

        // Length table.
        foreach (len_tbl[k]) begin
            do_reset();
            load_start = 1'b1;
            load_len   = len_tbl[k].len;
            tick();
            load_start = 1'b0;
            check("tbl_ready", in_ready, len_tbl[k].exp_ready);
            check("tbl_err", load_error, len_tbl[k].exp_error);
            check("tbl_hold", cpu_hold, 1);
            tick();
            check("tbl_ready2", in_ready, len_tbl[k].exp_ready);
            check("tbl_hold2", cpu_hold, 1);
            check("tbl_prog", prog, 0);
        end
        do_reset();
        obs_addr_q.delete();
        obs_data_q.delete();

        // Reset in the cycle of the 2nd transfer drops its pending write.
        wdata[0] = 32'h1111_0000; wdata[1] = 32'h2222_0001;
        load_start = 1'b1;
        load_len   = 32'd4;
        tick();
        load_start = 1'b0;
        in_valid = 1'b1;
        in_data  = wdata[0];
        tick();
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(wdata[0]);
        in_data = wdata[1];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_prog", prog, 0);
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_err", load_error, 0);
        check("mid_rst_code", code, 0);
        check("mid_rst_addr", addr, pc);
        tick();
        compare_writes("mid_rst");
        wdata[0] = 32'hCAFE_F00D;
        wgap[0] = 0;
        do_load("after_rst", 1);

        // Restart directly from DONE.
        wdata[0] = 32'hBEEF_0042;
        do_load("from_done", 1);

        // Randomized loads, some with gaps long enough to trip the watchdog.
        for (int r = 0; r < 12; r++) begin
            int len;
            len = $urandom_range(5, 1);
            pc  = $urandom;
            for (int i = 0; i < len; i++) begin
                wdata[i] = $urandom;
                wgap[i]  = ($urandom_range(6, 0) == 0) ? $urandom_range(10, 7) : $urandom_range(5, 0);
            end
            do_load("rand", len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench did not reach its end");
    end

endmodule : tb_module_imem_loader
